vga_scan_gen: RTL and testbench

//   Raster scan source for the pong display path. Generates the pixel x/y coordinates

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_scan_gen_if.sv | 33 +++
 rtl/vga_scan_gen_div.sv | 57 +++++
 rtl/vga_scan_gen.sv | 103 ++++++++++
 tb/tb_vga_scan_gen.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_pkg
// Brief  : 640x480@60 timing constants and shared types for the VGA scan path.
// Rev    : 1.0  initial release
// ============================================================================
package vga_pkg;

    localparam int CNT_W  = 10;
    localparam int RGB_W  = 12;

    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;

    localparam int H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END   = H_VIS + H_FP + H_SYNC;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END   = V_VIS + V_FP + V_SYNC;

    typedef logic [CNT_W-1:0] coord_t;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_scan_gen_if.sv
`default_nettype none
// ============================================================================
// Module : vga_scan_gen_if
// Brief  : Scan coordinates/timing out to the overlay logic, draw result back.
// Rev    : 1.0  initial release
// ============================================================================
interface vga_scan_gen_if #(
    parameter int RGB_W = vga_pkg::RGB_W
);
    logic             draw;
    logic [RGB_W-1:0] fg_color;
    logic [RGB_W-1:0] bg_color;
    logic [9:0]       x;
    logic [9:0]       y;
    logic             video_on;
    logic             p_tick;
    logic             frame_start;
    logic             hsync;
    logic             vsync;
    logic [RGB_W-1:0] rgb;

    modport master (
        input  draw, fg_color, bg_color,
        output x, y, video_on, p_tick, frame_start, hsync, vsync, rgb
    );

    modport slave (
        output draw, fg_color, bg_color,
        input  x, y, video_on, p_tick, frame_start, hsync, vsync, rgb
    );

endinterface : vga_scan_gen_if
`default_nettype wire

// File: rtl/vga_scan_gen_div.sv
`default_nettype none
// ============================================================================
// Module : pixel_tick_div
// Brief  : Mod-CLK_DIV counter producing a registered one-clock pixel strobe.
// Rev    : 1.0  initial release
// ============================================================================
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      p_tick_o
);

    generate
        if (CLK_DIV <= 1) begin : g_div1
            logic p_tick_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) p_tick_q <= 1'b0;
                else        p_tick_q <= 1'b1;
            end

            assign p_tick_o = p_tick_q;
        end else begin : g_divn
            localparam int            CW     = $clog2(CLK_DIV);
            localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          p_tick_q, p_tick_d;

            // Strobe is registered, so it appears on the clock after cnt hits C_LAST.
            always_comb begin
                cnt_d    = cnt_q + 1'b1;
                p_tick_d = 1'b0;
                if (cnt_q == C_LAST) begin
                    cnt_d    = '0;
                    p_tick_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q    <= '0;
                    p_tick_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    p_tick_q <= p_tick_d;
                end
            end

            assign p_tick_o = p_tick_q;
        end
    endgenerate

endmodule : pixel_tick_div
`default_nettype wire

// File: rtl/vga_scan_gen.sv
`default_nettype none
// ============================================================================
// Module : vga_scan_gen
// Brief  : VGA raster counters, sync decode and sync-aligned registered RGB.
// Rev    : 1.0  initial release
// ============================================================================
module vga_scan_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = vga_pkg::H_VIS,
    parameter int H_FP    = vga_pkg::H_FP,
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BP    = vga_pkg::H_BP,
    parameter int V_VIS   = vga_pkg::V_VIS,
    parameter int V_FP    = vga_pkg::V_FP,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_BP    = vga_pkg::V_BP,
    parameter int RGB_W   = vga_pkg::RGB_W
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    vga_scan_gen_if.master  bus
);
    import vga_pkg::*;

    localparam int     C_H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int     C_V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam coord_t C_X_LAST   = coord_t'(C_H_TOTAL - 1);
    localparam coord_t C_Y_LAST   = coord_t'(C_V_TOTAL - 1);
    localparam coord_t C_H_VIS    = coord_t'(H_VIS);
    localparam coord_t C_V_VIS    = coord_t'(V_VIS);
    localparam coord_t C_HS_START = coord_t'(H_VIS + H_FP);
    localparam coord_t C_HS_END   = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t C_VS_START = coord_t'(V_VIS + V_FP);
    localparam coord_t C_VS_END   = coord_t'(V_VIS + V_FP + V_SYNC);

    logic             p_tick;
    coord_t           x_q, x_d;
    coord_t           y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             video_on;
    logic             x_last, y_last;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .p_tick_o (p_tick)
    );

    assign x_last   = (x_q == C_X_LAST);
    assign y_last   = (y_q == C_Y_LAST);
    assign video_on = (x_q < C_H_VIS) && (y_q < C_V_VIS);

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        rgb_d   = rgb_q;
        if (p_tick) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            // Colour and syncs are sampled together so they leave aligned.
            hsync_d = !((x_q >= C_HS_START) && (x_q < C_HS_END));
            vsync_d = !((y_q >= C_VS_START) && (y_q < C_VS_END));
            rgb_d   = video_on ? (bus.draw ? bus.fg_color : bus.bg_color) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.video_on    = video_on;
    assign bus.p_tick      = p_tick;
    assign bus.frame_start = p_tick && x_last && y_last;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.rgb         = rgb_q;

endmodule : vga_scan_gen
`default_nettype wire

// File: tb/tb_vga_scan_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_vga_scan_gen
// Brief  : Directed and table-driven checks of vga_scan_gen in three builds.
// Rev    : 1.0  initial release
// ============================================================================
module tb_vga_scan_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst1_n, rst2_n;
    int   checks = 0;
    int   errors = 0;

    vga_scan_gen_if bus0 ();
    vga_scan_gen_if bus1 ();
    vga_scan_gen_if bus2 ();

    vga_scan_gen u_dut (
        .clk   (clk),
        .rst_n (rst0_n),
        .bus   (bus0)
    );

    vga_scan_gen #(
        .CLK_DIV (1)
    ) u_div1 (
        .clk   (clk),
        .rst_n (rst1_n),
        .bus   (bus1)
    );

    // Tiny raster: 15 x 10 totals, hsync x=10..12, vsync y=7..8.
    vga_scan_gen #(
        .CLK_DIV (2),
        .H_VIS   (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VIS   (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) u_small (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    typedef struct {
        int          x;
        int          y;
        logic        draw;
        logic [11:0] fg;
        logic [11:0] bg;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_small(input int tx, input int ty, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus2.p_tick && bus2.x == 10'(tx) && bus2.y == 10'(ty)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int hs_ticks, hs_clks, first_x, k1, k2, low_cnt, fs_cnt, fs1, fs2, vs_ticks, hs2_ticks;

        vecs[0] = '{1,  2, 1'b1, 12'hFFF, 12'h00F, 12'hFFF, 1'b1, 1'b1};
        vecs[1] = '{2,  2, 1'b0, 12'hFFF, 12'h00F, 12'h00F, 1'b1, 1'b1};
        vecs[2] = '{7,  5, 1'b1, 12'h5A5, 12'h00F, 12'h5A5, 1'b1, 1'b1};
        vecs[3] = '{8,  2, 1'b1, 12'hFFF, 12'h00F, 12'h000, 1'b1, 1'b1};
        vecs[4] = '{3,  6, 1'b1, 12'hFFF, 12'h00F, 12'h000, 1'b1, 1'b1};
        vecs[5] = '{11, 2, 1'b1, 12'hFFF, 12'h0F0, 12'h000, 1'b0, 1'b1};
        vecs[6] = '{3,  7, 1'b0, 12'hFFF, 12'h0F0, 12'h000, 1'b1, 1'b0};
        vecs[7] = '{0,  0, 1'b0, 12'h123, 12'hABC, 12'hABC, 1'b1, 1'b1};
        vecs[8] = '{14, 9, 1'b1, 12'hFFF, 12'hFFF, 12'h000, 1'b1, 1'b1};

        rst0_n = 1'b0; rst1_n = 1'b0; rst2_n = 1'b0;
        bus0.draw = 1'b0; bus0.fg_color = '0; bus0.bg_color = '0;
        bus1.draw = 1'b0; bus1.fg_color = '0; bus1.bg_color = '0;
        bus2.draw = 1'b0; bus2.fg_color = '0; bus2.bg_color = '0;

        // ---- reset values and first ticks ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst x", 32'(bus0.x), 0);
        check("rst y", 32'(bus0.y), 0);
        check("rst p_tick", 32'(bus0.p_tick), 0);
        check("rst frame_start", 32'(bus0.frame_start), 0);
        check("rst hsync", 32'(bus0.hsync), 1);
        check("rst vsync", 32'(bus0.vsync), 1);
        check("rst rgb", 32'(bus0.rgb), 0);
        rst0_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("p_tick clk %0d", k), 32'(bus0.p_tick), 32'((k % 4) == 0));
            if ((k % 4) == 0) begin
                check($sformatf("x at tick %0d", k / 4), 32'(bus0.x), 32'(k / 4 - 1));
                check($sformatf("y at tick %0d", k / 4), 32'(bus0.y), 0);
            end
        end
        check("early hsync", 32'(bus0.hsync), 1);
        check("early vsync", 32'(bus0.vsync), 1);
        check("early rgb", 32'(bus0.rgb), 0);

        // ---- one full line: wrap and hsync window ----
        hs_ticks = 0; hs_clks = 0; first_x = -1; ok = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (!bus0.hsync) begin
                hs_clks++;
                if (bus0.p_tick) begin
                    hs_ticks++;
                    if (first_x < 0) first_x = int'(bus0.x);
                end
            end
            if (bus0.p_tick && bus0.x == 10'd799) begin
                ok = 1'b1;
                break;
            end
        end
        check("line end reached", 32'(ok), 1);
        check("y before wrap", 32'(bus0.y), 0);
        check("hsync low ticks", 32'(hs_ticks), 96);
        check("hsync low clks", 32'(hs_clks), 384);
        check("hsync first low x", 32'(first_x), 657);
        repeat (4) @(negedge clk);
        check("wrap p_tick", 32'(bus0.p_tick), 1);
        check("x after wrap", 32'(bus0.x), 0);
        check("y after wrap", 32'(bus0.y), 1);

        // ---- reset mid-line ----
        bus0.bg_color = 12'h0F0;
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (bus0.p_tick && bus0.x == 10'd300) begin
                ok = 1'b1;
                break;
            end
        end
        check("reach x=300", 32'(ok), 1);
        @(negedge clk);
        check("pre-reset rgb", 32'(bus0.rgb), 32'h0F0);
        check("pre-reset x", 32'(bus0.x), 301);
        #2;
        rst0_n = 1'b0;
        #1;
        check("async rst x", 32'(bus0.x), 0);
        check("async rst y", 32'(bus0.y), 0);
        check("async rst rgb", 32'(bus0.rgb), 0);
        check("async rst p_tick", 32'(bus0.p_tick), 0);
        check("async rst hsync", 32'(bus0.hsync), 1);
        @(negedge clk);
        rst0_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("restart p_tick clk %0d", k), 32'(bus0.p_tick), 32'(k == 4));
        end
        check("restart x", 32'(bus0.x), 0);
        check("restart y", 32'(bus0.y), 0);

        // ---- CLK_DIV = 1 build ----
        @(negedge clk);
        rst1_n = 1'b1;
        k1 = -1; k2 = -1; low_cnt = 0; hs_clks = 0;
        for (int k = 1; k <= 1700; k++) begin
            @(negedge clk);
            if (!bus1.p_tick) low_cnt++;
            if (k1 >= 0 && k2 < 0 && !bus1.hsync) hs_clks++;
            if (bus1.x == 10'd799) begin
                if (k1 < 0) k1 = k;
                else if (k2 < 0) k2 = k;
            end
        end
        check("div1 p_tick held", 32'(low_cnt), 0);
        check("div1 line period", 32'(k2 - k1), 800);
        check("div1 hsync low clks", 32'(hs_clks), 96);

        // ---- table-driven colour/blanking/sync vectors on the tiny raster ----
        @(negedge clk);
        rst2_n = 1'b1;
        foreach (vecs[i]) begin
            wait_small(vecs[i].x, vecs[i].y, ok);
            check($sformatf("vec%0d reached", i), 32'(ok), 1);
            bus2.draw     = vecs[i].draw;
            bus2.fg_color = vecs[i].fg;
            bus2.bg_color = vecs[i].bg;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d rgb", i), 32'(bus2.rgb), 32'(vecs[i].rgb));
            check($sformatf("vec%0d hsync", i), 32'(bus2.hsync), 32'(vecs[i].hs));
            check($sformatf("vec%0d vsync", i), 32'(bus2.vsync), 32'(vecs[i].vs));
        end
        bus2.draw = 1'b0;

        // ---- frame_start cadence and per-frame sync counts (300 clk frame) ----
        fs_cnt = 0; fs1 = -1; fs2 = -1; vs_ticks = 0; hs2_ticks = 0;
        for (int k = 0; k < 900; k++) begin
            @(negedge clk);
            if (bus2.p_tick && !bus2.vsync) vs_ticks++;
            if (bus2.p_tick && !bus2.hsync) hs2_ticks++;
            if (bus2.frame_start) begin
                fs_cnt++;
                if (fs1 < 0) begin
                    fs1 = k;
                    check("frame_start x", 32'(bus2.x), 14);
                    check("frame_start y", 32'(bus2.y), 9);
                end else if (fs2 < 0) begin
                    fs2 = k;
                end
            end
        end
        check("frame_start count", 32'(fs_cnt), 3);
        check("frame period", 32'(fs2 - fs1), 300);
        check("vsync low ticks", 32'(vs_ticks), 90);
        check("small hsync low ticks", 32'(hs2_ticks), 90);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vga_scan_gen
`default_nettype wire
